// File: rtl/activation_feeder_pkg.sv
// Shared types and defaults for the activation feeder: word format and FSM state encoding.
package activation_feeder_pkg;

    localparam int N_DEF = 16;
    localparam int Q_DEF = 12;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_STREAM = 2'b01,
        ST_WAIT   = 2'b10
    } state_t;

    function automatic int buf_depth(input int side);
        return side * side;
    endfunction

endpackage

// File: rtl/activation_feeder_if.sv
// Host/accelerator-facing signal bundle of the activation feeder.
interface activation_feeder_if #(
    parameter int N  = 16,
    parameter int AW = 6
);
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [N-1:0]  wr_data;
    logic          start;
    logic          acc_done;
    logic [N-1:0]  act_out;
    logic          act_en;
    logic          busy;
    logic          done;
    logic          timeout;
    logic          wr_err;

    modport master (
        output wr_en, wr_addr, wr_data, start, acc_done,
        input  act_out, act_en, busy, done, timeout, wr_err
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, acc_done,
        output act_out, act_en, busy, done, timeout, wr_err
    );
endinterface

// File: rtl/activation_feeder_act_buffer.sv
// Activation buffer: one write port, one registered read port, no reset (BRAM/LUTRAM).
module act_buffer #(
    parameter int N = 16,
    parameter int D = 36
) (
    input  logic                        clk,
    input  logic                        we,
    input  logic [$clog2(D > 1 ? D : 2)-1:0] waddr,
    input  logic [N-1:0]                wdata,
    input  logic                        re,
    input  logic [$clog2(D > 1 ? D : 2)-1:0] raddr,
    output logic [N-1:0]                rdata
);

    logic [N-1:0] mem [D];

    // Write-first: a read of the word being written returns the new data.
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        if (re)
            rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
    end

endmodule

// File: rtl/activation_feeder.sv
// Streams an n*n activation buffer to the accelerator in raster order, then waits for its done.
module activation_feeder
    import activation_feeder_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int Q       = Q_DEF,
    parameter int n       = 6,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    activation_feeder_if.slave bus
);

    localparam int D  = buf_depth(n);
    localparam int AW = $clog2(D > 1 ? D : 2);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [AW-1:0] LAST_IDX  = AW'(D - 1);
    localparam logic [WW-1:0] LAST_WAIT = WW'(TIMEOUT - 1);

    if (TIMEOUT < 1 || Q < 0 || Q >= N) begin : g_bad_params
        $error("activation_feeder: illegal TIMEOUT or Q");
    end

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic [N-1:0]  act_out_q, act_out_d;
    logic          act_en_q, act_en_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          timeout_q, timeout_d;
    logic          wr_err_q, wr_err_d;

    logic          wr_ok;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [N-1:0]  rd_data;

    assign wr_ok = bus.wr_en && (state_q == ST_IDLE) && ({1'b0, bus.wr_addr} < (AW+1)'(D));

    // Reads run one index ahead of act_out; word 0 is fetched on the start edge.
    assign rd_en   = ((state_q == ST_IDLE) && bus.start) ||
                     ((state_q == ST_STREAM) && (idx_q != LAST_IDX));
    assign rd_addr = (state_q == ST_STREAM) ? idx_q + AW'(1) : '0;

    act_buffer #(.N(N), .D(D)) u_buf (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (bus.wr_addr),
        .wdata (bus.wr_data),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            wcnt_q    <= '0;
            act_out_q <= '0;
            act_en_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            wr_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            wcnt_q    <= wcnt_d;
            act_out_q <= act_out_d;
            act_en_q  <= act_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            wr_err_q  <= wr_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        wcnt_d    = wcnt_q;
        act_out_d = act_out_q;
        act_en_d  = 1'b0;
        done_d    = 1'b0;
        timeout_d = timeout_q;
        wr_err_d  = bus.wr_en && !wr_ok;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d   = ST_STREAM;
                    idx_d     = '0;
                    timeout_d = 1'b0;
                end
            end
            ST_STREAM: begin
                act_en_d  = 1'b1;
                act_out_d = rd_data;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_WAIT;
                    idx_d   = '0;
                    wcnt_d  = '0;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
            ST_WAIT: begin
                // The done cycle is still spent in WAIT, so a start seen there is ignored.
                if (done_q) begin
                    state_d = ST_IDLE;
                end else if (bus.acc_done) begin
                    done_d = 1'b1;
                end else if (wcnt_q == LAST_WAIT) begin
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + WW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    assign bus.act_out = act_out_q;
    assign bus.act_en  = act_en_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.timeout = timeout_q;
    assign bus.wr_err  = wr_err_q;

endmodule

// File: tb/tb_activation_feeder.sv
// Self-checking bench for activation_feeder: write table, streamed-frame scoreboard, corner sequences.
module tb_activation_feeder;

    localparam int D = 36;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    activation_feeder_if #(.N(16), .AW(6)) bus ();
    activation_feeder_if #(.N(16), .AW(6)) bus2 ();

    activation_feeder #(.N(16), .Q(12), .n(6), .TIMEOUT(1024)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    activation_feeder #(.N(16), .Q(12), .n(6), .TIMEOUT(8)) dut_to (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    typedef struct {
        logic [5:0]  addr;
        logic [15:0] data;
        logic        exp_err;
    } wvec_t;

    wvec_t       wv[$];
    logic [15:0] model [D];
    logic [15:0] exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock, sample just after the edge, and score any activation produced.
    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.act_en === 1'b1) begin
            if (exp_q.size() == 0)
                chk("act_en_unexpected", 32'd1, 32'd0);
            else
                chk("act_out", {16'h0, bus.act_out}, {16'h0, exp_q.pop_front()});
        end
    endtask

    task automatic push_frame();
        for (int i = 0; i < D; i++)
            exp_q.push_back(model[i]);
    endtask

    task automatic start_frame(input bit wr0);
        bus.start = 1'b1;
        if (wr0) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = 6'd0;
            bus.wr_data = 16'hABCD;
            model[0]    = 16'hABCD;
        end
        push_frame();
        tick();
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        chk("busy_after_start", {31'd0, bus.busy}, 32'd1);
        chk("act_en_latency", {31'd0, bus.act_en}, 32'd0);
        chk("timeout_cleared", {31'd0, bus.timeout}, 32'd0);
        chk("wr_err_start_cycle", {31'd0, bus.wr_err}, 32'd0);
    endtask

    task automatic stream_body(input int wr_at, input int ad_until);
        bit wr_pend = 1'b0;
        for (int k = 0; k < D; k++) begin
            bus.acc_done = (k < ad_until);
            tick();
            chk("act_en_stream", {31'd0, bus.act_en}, 32'd1);
            chk("busy_stream", {31'd0, bus.busy}, 32'd1);
            if (wr_pend) begin
                chk("wr_err_busy", {31'd0, bus.wr_err}, 32'd1);
                wr_pend = 1'b0;
            end
            bus.wr_en = 1'b0;
            if (k == wr_at) begin
                bus.wr_en   = 1'b1;
                bus.wr_addr = 6'd5;
                bus.wr_data = 16'h7FFF;
                wr_pend     = 1'b1;
            end
        end
        bus.acc_done = 1'b0;
        bus.wr_en    = 1'b0;
        tick();
        chk("act_en_end", {31'd0, bus.act_en}, 32'd0);
        chk("done_early", {31'd0, bus.done}, 32'd0);
        chk("stream_drained", exp_q.size(), 32'd0);
    endtask

    task automatic finish_frame(input int delay);
        for (int d = 0; d < delay; d++) begin
            tick();
            chk("done_wait", {31'd0, bus.done}, 32'd0);
            chk("busy_wait", {31'd0, bus.busy}, 32'd1);
        end
        bus.acc_done = 1'b1;
        tick();
        bus.acc_done = 1'b0;
        chk("done_pulse", {31'd0, bus.done}, 32'd1);
        chk("timeout_normal", {31'd0, bus.timeout}, 32'd0);
        chk("busy_done_cycle", {31'd0, bus.busy}, 32'd1);
        tick();
        chk("done_1cycle", {31'd0, bus.done}, 32'd0);
        chk("busy_idle", {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_act_out"}, {16'h0, bus.act_out}, 32'd0);
        chk({tag, "_act_en"}, {31'd0, bus.act_en}, 32'd0);
        chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, bus.done}, 32'd0);
        chk({tag, "_timeout"}, {31'd0, bus.timeout}, 32'd0);
        chk({tag, "_wr_err"}, {31'd0, bus.wr_err}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, n_err=%0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.wr_en = 1'b0;  bus.wr_addr = '0;  bus.wr_data = '0;
        bus.start = 1'b0;  bus.acc_done = 1'b0;
        bus2.wr_en = 1'b0; bus2.wr_addr = '0; bus2.wr_data = '0;
        bus2.start = 1'b0; bus2.acc_done = 1'b0;

        repeat (3) tick();
        chk_all_zero("reset");
        rst = 1'b0;

        bus.acc_done = 1'b1;
        tick();
        bus.acc_done = 1'b0;
        chk("acc_done_idle_ignored", {31'd0, bus.done}, 32'd0);

        // Buffer load plus out-of-range writes, table-driven.
        for (int i = 0; i < D; i++)
            wv.push_back('{addr: 6'(i), data: 16'(i * 16'h0100), exp_err: 1'b0});
        wv.push_back('{addr: 6'd36, data: 16'hDEAD, exp_err: 1'b1});
        wv.push_back('{addr: 6'd63, data: 16'hBEEF, exp_err: 1'b1});
        for (int v = 0; v < wv.size(); v++) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = wv[v].addr;
            bus.wr_data = wv[v].data;
            tick();
            chk("wr_err_table", {31'd0, bus.wr_err}, {31'd0, wv[v].exp_err});
            if (!wv[v].exp_err)
                model[wv[v].addr] = wv[v].data;
        end
        bus.wr_en = 1'b0;
        tick();
        chk("wr_err_clears", {31'd0, bus.wr_err}, 32'd0);

        // Frame with a rejected write mid-stream, acc_done 10 cycles after the stream.
        start_frame(1'b0);
        stream_body(4, 0);
        finish_frame(9);

        // Timeout on the TIMEOUT=8 instance, then acc_done coinciding with expiry.
        for (int f = 0; f < 2; f++) begin
            bus2.start = 1'b1;
            tick();
            bus2.start = 1'b0;
            chk("to_busy_start", {31'd0, bus2.busy}, 32'd1);
            chk("to_timeout_cleared", {31'd0, bus2.timeout}, 32'd0);
            for (int k = 0; k < D; k++) begin
                tick();
                chk("to_act_en", {31'd0, bus2.act_en}, 32'd1);
            end
            for (int k = 0; k < 7; k++) begin
                tick();
                chk("to_done_early", {31'd0, bus2.done}, 32'd0);
            end
            bus2.acc_done = (f == 1);
            tick();
            bus2.acc_done = 1'b0;
            chk("to_done_pulse", {31'd0, bus2.done}, 32'd1);
            chk("to_timeout_flag", {31'd0, bus2.timeout}, (f == 0) ? 32'd1 : 32'd0);
            tick();
            chk("to_done_1cycle", {31'd0, bus2.done}, 32'd0);
            chk("to_busy_idle", {31'd0, bus2.busy}, 32'd0);
            chk("to_timeout_sticky", {31'd0, bus2.timeout}, (f == 0) ? 32'd1 : 32'd0);
        end

        // Write to word 0 in the same cycle as start.
        start_frame(1'b1);
        stream_body(-1, 0);
        finish_frame(0);

        // Reset during the 10th active cycle, then a full frame from preserved contents.
        start_frame(1'b0);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("pre_rst_act_en", {31'd0, bus.act_en}, 32'd1);
        end
        #1 rst = 1'b1;
        #1;
        chk_all_zero("async_rst");
        exp_q.delete();
        tick();
        rst = 1'b0;
        chk("rst_no_done", {31'd0, bus.done}, 32'd0);
        start_frame(1'b0);
        stream_body(-1, 0);
        finish_frame(2);

        // start held across a frame; acc_done during STREAM must be ignored.
        bus.start = 1'b1;
        push_frame();
        tick();
        chk("held_busy", {31'd0, bus.busy}, 32'd1);
        stream_body(-1, D);
        finish_frame(3);
        push_frame();
        tick();
        chk("held_second_frame", {31'd0, bus.busy}, 32'd1);
        bus.start = 1'b0;
        stream_body(-1, 0);
        finish_frame(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
